adc045_avg: RTL and testbench

//  Downstream consumer of the two-channel ADC045 wrapper. Takes the per-channel 24-bit
//  two's-complement results and their one-cycle ready pulses, and block-averages 2**LOG2_N

---
 rtl/adc045_avg.sv | 111 +++++++++++
 tb/tb_adc045_avg.sv | 136 +++++++++++++
 2 files changed

// File: rtl/adc045_avg.sv
// adc045_avg: two-channel block averager feeding a tagged 2**FIFO_AW-deep valid/ready FIFO; ADC045_AVG_OVR_EN adds sticky overrange flags
module adc045_avg #(
  parameter int LOG2_N  = 4,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic        ready_ch1,
  input  logic        ready_ch2,
  input  logic [23:0] data_ch1,
  input  logic [23:0] data_ch2,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_chan,
  output logic [7:0]  m_seq,
  output logic [23:0] m_data,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  ovr
);
  localparam int AW = 24 + LOG2_N;
  localparam int CW = LOG2_N > 0 ? LOG2_N : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
  logic signed [AW-1:0] acc [2];
  logic signed [AW-1:0] sum [2];
  logic signed [23:0]   dat [2];
  logic [23:0]          avg [2];
  logic [CW-1:0]        cnt [2];
  logic [7:0]           seq [2];
  logic [31:0]          slot [2];
  logic                 pend [2];
  logic                 rdy [2];
  logic                 done [2];
  logic                 wr [2];
  logic                 drop [2];
  logic [32:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wp, rp;
  logic [FIFO_AW:0]     fcnt;
  logic [8:0]           dsum;
  logic                 pop, push, sel;
  always_comb begin
    dat[0] = data_ch1;
    dat[1] = data_ch2;
    rdy[0] = ready_ch1 & enable;
    rdy[1] = ready_ch2 & enable;
    m_valid = |fcnt;
    pop = m_valid & m_ready;
    sel = !pend[0];
    push = (pend[0] | pend[1]) & (fcnt != FULL | pop);
    wr[0] = push & !sel;
    wr[1] = push & sel;
    for (int k = 0; k < 2; k++) begin
      sum[k] = acc[k] + AW'(dat[k]);
      avg[k] = 24'(sum[k] >>> LOG2_N);
      done[k] = rdy[k] && cnt[k] == LAST;
      drop[k] = done[k] & pend[k] & !wr[k];
    end
    dsum = {1'b0, drop_cnt} + 9'(drop[0]) + 9'(drop[1]);
    {m_chan, m_seq, m_data} = m_valid ? mem[rp] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      for (int k = 0; k < 2; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
        seq[k] <= '0;
        pend[k] <= 1'b0;
        slot[k] <= '0;
      end
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!enable || done[k]) begin
          acc[k] <= '0;
          cnt[k] <= '0;
        end else if (rdy[k]) begin
          acc[k] <= sum[k];
          cnt[k] <= cnt[k] + CW'(1);
        end
        if (done[k]) begin
          seq[k] <= seq[k] + 8'd1;
          slot[k] <= {seq[k], avg[k]};
        end
        pend[k] <= done[k] | (pend[k] & !wr[k]);
      end
      if (push) wp <= wp + FIFO_AW'(1);
      if (pop) rp <= rp + FIFO_AW'(1);
      fcnt <= fcnt + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
      drop_cnt <= dsum[8] ? 8'hFF : dsum[7:0];
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= sel ? {1'b1, slot[1]} : {1'b0, slot[0]};
  end
`ifdef ADC045_AVG_OVR_EN
  logic [1:0] ovr_r;
  always_ff @(posedge clk) begin
    if (rst | flush) ovr_r <= '0;
    else for (int k = 0; k < 2; k++) ovr_r[k] <= ovr_r[k] | (rdy[k] && (dat[k] == 24'sh7FFFFF || dat[k] == 24'sh800000));
  end
  assign ovr = ovr_r;
`else
  assign ovr = 2'b00;
`endif
endmodule

// File: tb/tb_adc045_avg.sv
// tb_adc045_avg: scoreboard bench for adc045_avg with LOG2_N=2 directed vectors
module tb_adc045_avg;
  logic clk = 0, rst = 1, enable = 0, flush = 0, ready_ch1 = 0, ready_ch2 = 0, m_ready = 1;
  logic [23:0] data_ch1 = '0, data_ch2 = '0;
  logic m_valid, m_chan;
  logic [7:0] m_seq, drop_cnt;
  logic [23:0] m_data;
  logic [1:0] ovr, ovr_exp;
  int n_chk = 0, n_fail = 0;
  logic [32:0] exp_q[$];
  adc045_avg #(.LOG2_N(2), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .ready_ch1(ready_ch1), .ready_ch2(ready_ch2), .data_ch1(data_ch1), .data_ch2(data_ch2),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_seq(m_seq), .m_data(m_data),
    .drop_cnt(drop_cnt), .ovr(ovr)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected none", {m_chan, m_seq, m_data});
      end else check("beat", {m_chan, m_seq, m_data}, exp_q.pop_front());
    end
  end
  task automatic pulse(input logic r1, input logic [23:0] d1, input logic r2, input logic [23:0] d2);
    ready_ch1 = r1;
    data_ch1 = d1;
    ready_ch2 = r2;
    data_ch2 = d2;
    @(posedge clk);
    #1;
    ready_ch1 = 0;
    ready_ch2 = 0;
  endtask
  task automatic blk(input logic ch, input logic [23:0] a, input logic [23:0] b, input logic [23:0] c, input logic [23:0] d);
    pulse(!ch, a, ch, a);
    pulse(!ch, b, ch, b);
    pulse(!ch, c, ch, c);
    pulse(!ch, d, ch, d);
  endtask
  task automatic expect_beat(input logic ch, input logic [7:0] s, input logic [23:0] d);
    exp_q.push_back({ch, s, d});
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_left", 33'(exp_q.size()), 33'd0);
  endtask
  initial begin
`ifdef ADC045_AVG_OVR_EN
    ovr_exp = 2'b01;
`else
    ovr_exp = 2'b00;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_valid", 33'(m_valid), 33'd0);
    check("rst_drop", 33'(drop_cnt), 33'd0);
    check("rst_ovr", 33'(ovr), 33'd0);
    check("rst_head", {m_chan, m_seq, m_data}, 33'd0);
    @(posedge clk);
    #1 enable = 1;
    expect_beat(0, 8'd0, 24'h00000A);
    blk(0, 24'd4, 24'd8, 24'd12, 24'd16);
    @(negedge clk);
    check("lat_e0", 33'(m_valid), 33'd0);
    @(negedge clk);
    check("lat_e1", 33'(m_valid), 33'd1);
    drain();
    expect_beat(1, 8'd0, 24'hFFFFFF);
    blk(1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000);
    drain();
    expect_beat(0, 8'd1, 24'h000003);
    expect_beat(1, 8'd1, 24'h000100);
    pulse(1, 24'd1, 1, 24'h100);
    pulse(1, 24'd2, 1, 24'h100);
    pulse(1, 24'd3, 1, 24'h100);
    pulse(1, 24'd6, 1, 24'h100);
    drain();
    expect_beat(0, 8'd2, 24'h000002);
    pulse(1, 24'd100, 0, 24'd0);
    pulse(1, 24'd100, 0, 24'd0);
    enable = 0;
    @(posedge clk);
    #1 enable = 1;
    blk(0, 24'd1, 24'd2, 24'd3, 24'd2);
    drain();
    m_ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (i != 4) expect_beat(0, 8'(3 + i), 24'(10 * (i + 1)));
      blk(0, 24'(10 * (i + 1)), 24'(10 * (i + 1)), 24'(10 * (i + 1)), 24'(10 * (i + 1)));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_drop", 33'(drop_cnt), 33'd1);
    check("bp_valid", 33'(m_valid), 33'd1);
    check("bp_head_seq", 33'(m_seq), 33'd3);
    check("bp_head_data", 33'(m_data), 33'd10);
    m_ready = 1;
    drain();
    check("drop_hold", 33'(drop_cnt), 33'd1);
    expect_beat(0, 8'd9, 24'h7FFFFF);
    blk(0, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
    drain();
    check("ovr_set", 33'(ovr), 33'(ovr_exp));
    m_ready = 0;
    blk(1, 24'd5, 24'd5, 24'd5, 24'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_flush_valid", 33'(m_valid), 33'd1);
    @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("flush_valid", 33'(m_valid), 33'd0);
    check("flush_drop", 33'(drop_cnt), 33'd0);
    check("flush_ovr", 33'(ovr), 33'd0);
    m_ready = 1;
    expect_beat(0, 8'd0, 24'h00000A);
    blk(0, 24'd4, 24'd8, 24'd12, 24'd16);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
